i2s_shift_engine: RTL
=====================

Name: i2s_shift_engine

Overview:
Serial I2S master stage sitting directly downstream/upstream of the APB playback/capture FIFO block.
- Generates BCLK/LRCLK from clk.
- Serializes 64-bit playback words (left = [63:32], right = [31:0], MSB-first) onto i2s_dout.
- Deserializes i2s_din into 64-bit capture words.
- Handshakes with the FIFO block using level pulses long enough for its 3-flop synchronizer and falling-edge detector.

Parameters:
- BCLK_DIV, 4: clk cycles per BCLK half-period; legal values ≥2.
- PULSE_LEN, 4: clk cycles that the ack and write strobes stay high; legal values 3..(2*BCLK_DIV*32).

Ports:
- clk  in  1  interface clock
- reset_n  in  1  synchronous, active-low reset
- playback_fifo_data  in  64  head word of playback FIFO
- playback_fifo_empty  in  1  playback FIFO empty
- i2s_playback_enable  in  1  playback allowed (DMA enabled and FIFO not empty)
- i2s_playback_fifo_ack  out  1  word-consumed pulse; FIFO pops on its falling edge
- capture_fifo_data  out  64  assembled capture word, left in [63:32]
- i2s_capture_fifo_write  out  1  capture-word-ready pulse; FIFO writes on its falling edge
- i2s_capture_enable  in  1  capture allowed (DMA enabled and FIFO not full)
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_dout  out  1  serial playback data
- i2s_din  in  1  serial capture data

Behaviour:
- Reset (reset_n=0 sampled at posedge clk):
  - div_cnt=0, i2s_bclk=0, i2s_lrclk=0, i2s_dout=0, bit index b=63.
  - Ack/write pulse counters=0; i2s_playback_fifo_ack=0; i2s_capture_fifo_write=0.
  - capture_fifo_data=0, tx_shift=0, rx_shift=0, cap_armed=0.
  - Reset mid-frame aborts the frame. No ack or write is issued for it.
- Clock generation:
  - div_cnt counts 0..BCLK_DIV-1; at the wrap, i2s_bclk toggles.
  - rise_stb and fall_stb are single-clk strobes coincident with the toggle cycle.
  - BCLK period = 2*BCLK_DIV clk; frame = 64 BCLK.
- On fall_stb:
  - b increments mod 64.
  - i2s_lrclk = 1 for b in 31..62, 0 for b=63 and 0..30. LRCLK therefore leads the slot MSB by one BCLK (I2S delay).
- Frame start (fall_stb with b 63→0):
  - If i2s_playback_enable=1 and playback_fifo_empty=0: tx_shift ← playback_fifo_data, and the ack counter loads PULSE_LEN.
  - Otherwise tx_shift ← 0 and no ack is issued.
  - i2s_dout ← MSB of the newly loaded value in the same cycle.
- Other fall_stb: tx_shift shifts left by 1; i2s_dout ← new MSB.
- i2s_playback_fifo_ack is high for exactly PULSE_LEN clk, starting the cycle after the frame-start strobe. At most one ack per frame.
- Enable deasserted mid-frame: the current (already acked) word completes; the next frame carries zeros.
- On rise_stb: rx_shift ← {rx_shift[62:0], i2s_din}.
- Capture arming:
  - At frame start, cap_armed ← i2s_capture_enable.
  - If i2s_capture_enable=0 at any rise_stb, cap_armed ← 0 for the rest of that frame.
- On rise_stb at b=63 (64th bit):
  - One clk later, capture_fifo_data ← completed rx_shift.
  - If cap_armed=1, the write counter loads PULSE_LEN.
  - capture_fifo_data then holds stable until the next frame completion.
- i2s_capture_fifo_write is high for PULSE_LEN clk; no partial frames are ever written.
- Loopback (dout→din): a captured word equals the played word, one frame after playback.
- Pulse counters saturate at 0. A new load while a counter is nonzero cannot occur for legal PULSE_LEN.

Decomposition:
- Package i2s_pkg:
  - FRAME_BITS=64, SLOT_BITS=32, MIN_PULSE=3.
  - LRCLK_RISE_BIT=31, LRCLK_FALL_BIT=63.
  - Sample word typedef (left/right 32-bit struct).
- One sub-module, i2s_clkgen:
  - Contains the divider, i2s_bclk, rise_stb/fall_stb, bit index b and i2s_lrclk.
  - Parameterized by BCLK_DIV.
- The top module holds tx/rx shift registers, arming logic and the pulse generators.

Test Plan:
1. BCLK_DIV=4, idle → i2s_bclk period 8 clk, i2s_lrclk period 512 clk, i2s_lrclk falls exactly 8 clk before the first MSB fall_stb.
2. playback_fifo_data=64'hA5A50001_800000FF with enable=1, empty=0 → i2s_dout bit sequence 1,0,1,0,0,1,0,1… (left), right slot starts with 1; i2s_playback_fifo_ack high 4 clk starting 1 clk after frame start; one ack per frame.
3. playback_fifo_empty=1 → i2s_dout constant 0 for the whole frame, i2s_playback_fifo_ack never asserted.
4. Loopback i2s_dout→i2s_din, capture enabled, word 64'h12345678_9ABCDEF0 → capture_fifo_data=64'h12345678_9ABCDEF0, i2s_capture_fifo_write high 4 clk, one per frame.
5. i2s_capture_enable raised at b=20 → no write for that frame, first write at end of next frame. i2s_playback_enable dropped at b=10 → current word completes, next frame is zeros.
6. reset_n=0 for 2 clk at b=40 → all outputs at reset values, no ack/write pulse, normal framing resumes from b=63.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S shift engine and its clock generator.
package i2s_pkg;

  localparam int FRAME_BITS     = 64;
  localparam int SLOT_BITS      = 32;
  localparam int MIN_PULSE      = 3;
  localparam int LRCLK_RISE_BIT = 31;
  localparam int LRCLK_FALL_BIT = 63;
  localparam int BIT_W          = $clog2(FRAME_BITS);

  typedef struct packed {
    logic [SLOT_BITS-1:0] left;
    logic [SLOT_BITS-1:0] right;
  } sample_t;

  // Word select is high one BCLK ahead of the right slot and drops one BCLK ahead of the left slot.
  function automatic logic lrclk_for_bit(input logic [BIT_W-1:0] b);
    return (b >= BIT_W'(LRCLK_RISE_BIT)) && (b < BIT_W'(LRCLK_FALL_BIT));
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK/LRCLK generation from clk, with single-clk edge strobes and the frame bit index.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             i2s_bclk,
  output logic             i2s_lrclk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [BIT_W-1:0] bit_idx
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic [BIT_W-1:0] bit_nxt;

  assign div_wrap = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign rise_stb = div_wrap && !i2s_bclk;
  assign fall_stb = div_wrap && i2s_bclk;
  assign bit_nxt  = bit_idx + BIT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Bit index advances on the falling BCLK; reset parks it on the last bit so the next fall starts a frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_idx   <= BIT_W'(FRAME_BITS - 1);
      i2s_lrclk <= 1'b0;
    end else if (fall_stb) begin
      bit_idx   <= bit_nxt;
      i2s_lrclk <= lrclk_for_bit(bit_nxt);
    end
  end

endmodule

// File: rtl/i2s_shift_engine.sv
// I2S master shift engine: serializes playback words, assembles capture words and
// issues FIFO handshake pulses long enough for a 3-flop synchronizer downstream.
module i2s_shift_engine
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV  = 4,
  parameter int PULSE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [FRAME_BITS-1:0] playback_fifo_data,
  input  logic                  playback_fifo_empty,
  input  logic                  i2s_playback_enable,
  output logic                  i2s_playback_fifo_ack,
  output logic [FRAME_BITS-1:0] capture_fifo_data,
  output logic                  i2s_capture_fifo_write,
  input  logic                  i2s_capture_enable,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_dout,
  input  logic                  i2s_din
);

  localparam int               CNT_W    = $clog2(PULSE_LEN + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] PULSE_RL = CNT_W'(PULSE_LEN - 1);

  logic                  rise_stb;
  logic                  fall_stb;
  logic [BIT_W-1:0]      bit_idx;
  logic                  frame_start;
  logic                  frame_end;
  logic                  play_ok;
  logic [FRAME_BITS-1:0] tx_load;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] rx_shift;
  logic                  cap_armed;
  logic                  cap_vld_p1;
  sample_t               cap_word;
  logic                  ack_load;
  logic                  wr_load;
  logic [CNT_W-1:0]      ack_cnt;
  logic [CNT_W-1:0]      wr_cnt;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .bit_idx   (bit_idx)
  );

  assign frame_start       = fall_stb && (bit_idx == LAST_BIT);
  assign frame_end         = rise_stb && (bit_idx == LAST_BIT);
  assign play_ok           = i2s_playback_enable && !playback_fifo_empty;
  assign tx_load           = play_ok ? playback_fifo_data : '0;
  assign ack_load          = frame_start && play_ok;
  assign wr_load           = cap_vld_p1 && cap_armed;
  assign i2s_dout          = tx_shift[FRAME_BITS-1];
  assign capture_fifo_data = cap_word;

  // Playback stage: the MSB of tx_shift is the serial output, so dout follows every load and shift
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_shift <= '0;
    end else if (frame_start) begin
      tx_shift <= tx_load;
    end else if (fall_stb) begin
      tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Capture stage p0: sample din on rising BCLK; a single disabled rise disarms the whole frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_shift   <= '0;
      cap_armed  <= 1'b0;
      cap_vld_p1 <= 1'b0;
    end else begin
      cap_vld_p1 <= frame_end;
      if (rise_stb) begin
        rx_shift <= {rx_shift[FRAME_BITS-2:0], i2s_din};
      end
      if (frame_start) begin
        cap_armed <= i2s_capture_enable;
      end else if (rise_stb && !i2s_capture_enable) begin
        cap_armed <= 1'b0;
      end
    end
  end

  // Capture stage p1: hand the completed word over once its last bit has landed in rx_shift
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_word <= '0;
    end else if (cap_vld_p1) begin
      cap_word <= rx_shift;
    end
  end

  // Handshake pulses are registered flags; the counter holds the remaining high cycles after the first
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_cnt               <= '0;
      i2s_playback_fifo_ack <= 1'b0;
    end else if (ack_load) begin
      ack_cnt               <= PULSE_RL;
      i2s_playback_fifo_ack <= 1'b1;
    end else begin
      ack_cnt               <= sat_dec(ack_cnt);
      i2s_playback_fifo_ack <= (ack_cnt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_cnt                 <= '0;
      i2s_capture_fifo_write <= 1'b0;
    end else if (wr_load) begin
      wr_cnt                 <= PULSE_RL;
      i2s_capture_fifo_write <= 1'b1;
    end else begin
      wr_cnt                 <= sat_dec(wr_cnt);
      i2s_capture_fifo_write <= (wr_cnt != '0);
    end
  end

endmodule
